// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/operand request and result bundle; ovf exists only with SHIFT_SEQ_OVF_EN.
interface shift_sequencer_if;
  logic       start;
  logic [7:0] din;
  logic [3:0] amt;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic [1:0] shift_ctrl;
`ifdef SHIFT_SEQ_OVF_EN
  logic       ovf;
  modport master (output start, din, amt, input busy, done, dout, shift_ctrl, ovf);
  modport slave  (input start, din, amt, output busy, done, dout, shift_ctrl, ovf);
`else
  modport master (output start, din, amt, input busy, done, dout, shift_ctrl);
  modport slave  (input start, din, amt, output busy, done, dout, shift_ctrl);
`endif
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle left shifter, at most STEP_MAX bits per cycle.
// Optional overflow flag when SHIFT_SEQ_OVF_EN is defined.
module shift_sequencer #(
  parameter int STEP_MAX = 3
) (
  input logic clk,
  input logic rst,
  shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] SM = 4'(STEP_MAX);
  state_t      state;
  logic [7:0]  work;
  logic [3:0]  rem;
  logic [15:0] shifted;
  logic [3:0]  nrem;
  assign shifted = {8'b0, work} << bus.shift_ctrl;
  assign nrem = rem - {2'b0, bus.shift_ctrl};
  function automatic logic [1:0] step(input logic [3:0] r);
    return r > SM ? SM[1:0] : r[1:0];
  endfunction
  // shift_ctrl is precomputed one edge ahead so it is registered yet always min(rem, STEP_MAX) in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      work           <= '0;
      rem            <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.dout       <= '0;
      bus.shift_ctrl <= '0;
`ifdef SHIFT_SEQ_OVF_EN
      bus.ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          work           <= bus.din;
          rem            <= bus.amt;
          bus.shift_ctrl <= step(bus.amt);
          bus.busy       <= 1'b1;
`ifdef SHIFT_SEQ_OVF_EN
          bus.ovf        <= 1'b0;
`endif
          state          <= RUN;
        end
        RUN: begin
          work <= shifted[7:0];
          rem  <= nrem;
`ifdef SHIFT_SEQ_OVF_EN
          bus.ovf <= bus.ovf | (|shifted[15:8]);
`endif
          if (nrem == 4'd0) begin
            state          <= DONE;
            bus.dout       <= shifted[7:0];
            bus.done       <= 1'b1;
            bus.shift_ctrl <= '0;
          end else
            bus.shift_ctrl <= step(nrem);
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks on STEP_MAX=3 and STEP_MAX=1 instances.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;
  shift_sequencer_if i3 ();
  shift_sequencer_if i1 ();
  shift_sequencer #(.STEP_MAX(3)) u3 (.clk(clk), .rst(rst), .bus(i3));
  shift_sequencer #(.STEP_MAX(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic st3(input string tag, input logic b, input logic d, input logic [1:0] c);
    chk({tag, ".busy"}, 8'(i3.busy), 8'(b));
    chk({tag, ".done"}, 8'(i3.done), 8'(d));
    chk({tag, ".ctrl"}, 8'(i3.shift_ctrl), 8'(c));
  endtask
  initial begin
    i3.start = 0; i3.din = 0; i3.amt = 0;
    i1.start = 0; i1.din = 0; i1.amt = 0;
    @(negedge clk);
    st3("rst", 0, 0, 0);
    chk("rst.dout", i3.dout, 8'h00);
    rst = 0;
    // 0x01 << 7 in steps 3,3,1; inputs changed after accept must not matter
    @(negedge clk); i3.start = 1; i3.din = 8'h01; i3.amt = 4'd7;
    @(negedge clk); i3.start = 0; i3.din = 8'hFF; i3.amt = 4'd15;
    st3("a7.r1", 1, 0, 3);
    @(negedge clk); st3("a7.r2", 1, 0, 3);
    @(negedge clk); st3("a7.r3", 1, 0, 1);
    @(negedge clk); st3("a7.dn", 1, 1, 0);
    chk("a7.dout", i3.dout, 8'h80);
    @(negedge clk); st3("a7.idle", 0, 0, 0);
    chk("a7.hold", i3.dout, 8'h80);
    // amt=0: one RUN cycle with shift 0
    i3.start = 1; i3.din = 8'hA5; i3.amt = 4'd0;
    @(negedge clk); i3.start = 0;
    st3("a0.r1", 1, 0, 0);
    @(negedge clk); st3("a0.dn", 1, 1, 0);
    chk("a0.dout", i3.dout, 8'hA5);
    @(negedge clk); st3("a0.idle", 0, 0, 0);
    // amt=12 of 0xFF
    i3.start = 1; i3.din = 8'hFF; i3.amt = 4'd12;
    @(negedge clk); i3.start = 0;
    st3("a12.r1", 1, 0, 3);
    @(negedge clk); st3("a12.r2", 1, 0, 3);
    @(negedge clk); st3("a12.r3", 1, 0, 3);
    @(negedge clk); st3("a12.r4", 1, 0, 3);
    @(negedge clk); st3("a12.dn", 1, 1, 0);
    chk("a12.dout", i3.dout, 8'h00);
`ifdef SHIFT_SEQ_OVF_EN
    chk("a12.ovf", 8'(i3.ovf), 8'd1);
`endif
    @(negedge clk); st3("a12.idle", 0, 0, 0);
    // start held high: dropped in DONE, re-accepted from IDLE
    i3.start = 1; i3.din = 8'h03; i3.amt = 4'd2;
    @(negedge clk); st3("hold.r1", 1, 0, 2);
    @(negedge clk); st3("hold.dn", 1, 1, 0);
    chk("hold.dout1", i3.dout, 8'h0C);
    @(negedge clk); st3("hold.idle", 0, 0, 0);
    @(negedge clk); st3("hold.r2", 1, 0, 2);
    @(negedge clk); st3("hold.dn2", 1, 1, 0);
    chk("hold.dout2", i3.dout, 8'h0C);
    i3.start = 0;
    @(negedge clk); st3("hold.end", 0, 0, 0);
    // reset during second RUN cycle of amt=9
    i3.start = 1; i3.din = 8'h01; i3.amt = 4'd9;
    @(negedge clk); i3.start = 0;
    st3("r9.r1", 1, 0, 3);
    @(negedge clk); st3("r9.r2", 1, 0, 3);
    #1 rst = 1;
    #1 st3("r9.rst", 0, 0, 0);
    chk("r9.dout", i3.dout, 8'h00);
    @(negedge clk); rst = 0;
    @(negedge clk); st3("r9.q1", 0, 0, 0);
    @(negedge clk); st3("r9.q2", 0, 0, 0);
    i3.start = 1; i3.din = 8'h01; i3.amt = 4'd1;
    @(negedge clk); i3.start = 0;
    st3("r1.r1", 1, 0, 1);
    @(negedge clk); st3("r1.dn", 1, 1, 0);
    chk("r1.dout", i3.dout, 8'h02);
    // STEP_MAX=1 instance
    i1.start = 1; i1.din = 8'h81; i1.amt = 4'd1;
    @(negedge clk); i1.start = 0;
    chk("s1.ctrl", 8'(i1.shift_ctrl), 8'd1);
    chk("s1.done0", 8'(i1.done), 8'd0);
    @(negedge clk);
    chk("s1.done", 8'(i1.done), 8'd1);
    chk("s1.dout", i1.dout, 8'h02);
`ifdef SHIFT_SEQ_OVF_EN
    chk("s1.ovf", 8'(i1.ovf), 8'd1);
`endif
    i1.start = 1; i1.din = 8'h01; i1.amt = 4'd3;
    @(negedge clk);
    @(negedge clk); i1.start = 0;
    chk("s3.c1", 8'(i1.shift_ctrl), 8'd1);
    @(negedge clk); chk("s3.c2", 8'(i1.shift_ctrl), 8'd1);
    @(negedge clk); chk("s3.c3", 8'(i1.shift_ctrl), 8'd1);
    @(negedge clk);
    chk("s3.done", 8'(i1.done), 8'd1);
    chk("s3.dout", i1.dout, 8'h08);
`ifdef SHIFT_SEQ_OVF_EN
    chk("s3.ovf", 8'(i1.ovf), 8'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
